div_unit: RTL

Multi-cycle 32-bit integer divider and its sequencing FSM for the EX stage. It serves DIV and DIVU. EX raises `start_i` with the operands and holds the pipeline, via `stallreq_o`, until the quotient and remainder are ready. The block runs a radix-2 restoring divide, one quotient bit per cycle. It can be annulled mid-operation by a pipeline flush.

---
 rtl/div_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH iterations; abandoned immediately on annul.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quot_next;
    logic                 last_iter;
    logic                 start_ok;
    logic                 dsr_zero;

    assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
    assign start_ok   = start_i & ~annul_i;
    assign dsr_zero   = (divisor_i == '0);
    assign stallreq_o = start_i & ~ready_q & ~annul_i;
    assign result_o   = result_q;
    assign ready_o    = ready_q;

    // Shifted remainder needs WIDTH+1 bits; a set MSB of trial means the subtract went negative.
    always_comb begin
        trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, dsr_q};
        quot_next = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        if (trial[WIDTH]) begin
            rem_next = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
        end else begin
            rem_next = trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = dsr_zero ? StByZero : StOn;
                end
            end
            StByZero: state_d = annul_i ? StIdle : StEnd;
            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                if (annul_i || !start_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        quot_d     = quot_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok && !dsr_zero) begin
                    quot_d     = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                    dsr_d      = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quot_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    neg_rem_d  = signed_i & dividend_i[WIDTH-1];
                end
            end
            StByZero: begin
                result_d = '0;
                ready_d  = ~annul_i;
            end
            StOn: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    quot_d = quot_next;
                    rem_d  = rem_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_d = {neg_rem_q ? -rem_next : rem_next,
                                    neg_quot_q ? -quot_next : quot_next};
                        ready_d  = 1'b1;
                    end
                end
            end
            StEnd: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quot_q     <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            quot_q     <= quot_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

endmodule
